// File: rtl/piso_bit_tx_if.sv
// ============================================================================
// Module   : piso_bit_tx_if
// Brief    : Parallel-load handshake bundle for the serial bit transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_bit_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

`default_nettype wire

// File: rtl/piso_bit_tx.sv
// ============================================================================
// Module   : piso_bit_tx
// Brief    : Framed LSB-first serial transmitter with complementary q/qn line.
//            Optional even-parity bit enabled by defining PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_bit_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic         clk,
    input  logic         clr,
    piso_bit_tx_if.slave ld,
    output logic         q,
    output logic         qn,
    output logic         busy,
    output logic         done
);

    localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_DIV_PRE  = c_CW'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [c_CW-1:0] c_DIV_ONE  = c_CW'(1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [2:0]       r_state;
    logic             r_q;
    logic             r_qn;
    logic             r_busy;
    logic             r_done;
    logic [c_CW-1:0]  r_div_cnt;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
`ifdef PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    logic [2:0]       w_state_nxt;
    logic             w_q_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [c_CW-1:0]  w_div_nxt;
    logic [c_BW-1:0]  w_bit_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_bit_end;
    logic             w_enter_stop;

    assign w_load_ready  = (r_state == c_IDLE) && !clr;
    assign w_accept      = ld.load_valid && w_load_ready;
    assign w_bit_end     = (r_div_cnt == c_DIV_LAST);
    assign ld.load_ready = w_load_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_div_nxt    = r_div_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_enter_stop = 1'b0;
`ifdef PARITY_EN
        w_parity_nxt = r_parity;
`endif

        case (r_state)
            c_IDLE: begin
                w_q_nxt = 1'b1;
                if (w_accept) begin
                    w_shift_nxt = ld.data_in;
`ifdef PARITY_EN
                    w_parity_nxt = ^ld.data_in;
`endif
                    w_state_nxt = c_START;
                    w_q_nxt     = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end

            c_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_DATA;
                    w_q_nxt     = r_shift[0];
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_ONE;
                end
            end

            c_DATA: begin
                if (w_bit_end) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == c_BIT_LAST) begin
`ifdef PARITY_EN
                        w_state_nxt = c_PARITY;
                        w_q_nxt     = r_parity;
`else
                        w_enter_stop = 1'b1;
`endif
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_q_nxt     = w_shift_nxt[0];
                        w_bit_nxt   = r_bit_cnt + c_BIT_ONE;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_ONE;
                end
            end

`ifdef PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    w_enter_stop = 1'b1;
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_ONE;
                end
            end
`endif

            // The FSM leaves STOP one cycle early: the final stop-bit cycle is
            // spent in IDLE with done high, so a word accepted there follows
            // the stop bit with no idle gap.
            c_STOP: begin
                if (r_div_cnt == c_DIV_PRE) begin
                    w_state_nxt = c_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_ONE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_q_nxt     = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_enter_stop) begin
            w_q_nxt   = 1'b1;
            w_div_nxt = '0;
            if (DIV == 1) begin
                w_state_nxt = c_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = c_STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_IDLE;
            r_q       <= 1'b1;
            r_qn      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_qn      <= ~w_q_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
`ifdef PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    assign q    = r_q;
    assign qn   = r_qn;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire
